// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline stage register.
// Holds the stage-contents struct, reset/handler PCs and the per-edge action encoding.
package pipe_pkg;

  localparam int EXC_W       = 5;
  localparam int PC_W_DEF    = 32;
  localparam int INSTR_W_DEF = 32;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;

  localparam logic [EXC_W-1:0] EXC_NONE = '0;

  typedef struct packed {
    logic                   valid;
    logic [PC_W_DEF-1:0]    pc;
    logic [INSTR_W_DEF-1:0] instr;
    logic [EXC_W-1:0]       exccode;
    logic                   bd;
  } stage_t;

  typedef enum logic [1:0] {
    ACT_LOAD,
    ACT_STALL,
    ACT_FLUSH,
    ACT_REQ
  } stage_act_e;

  // Fixed priority: exception request beats flush beats stall beats load.
  function automatic stage_act_e selectAction(input logic req, input logic flush,
                                              input logic stall);
    if (req)   return ACT_REQ;
    if (flush) return ACT_FLUSH;
    if (stall) return ACT_STALL;
    return ACT_LOAD;
  endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter used for the stage's optional performance statistics.
// It stops at all-ones and never wraps back to zero.
module pipe_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with stall, flush-to-bubble and exception redirect.
// Define PIPE_PERF_EN to add saturating stall/bubble counters (stall_cnt, bubble_cnt).
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          PC_W       = 32,
  parameter int          INSTR_W    = 32,
  parameter int          EXC_W      = pipe_pkg::EXC_W,
  parameter logic [31:0] RESET_PC   = pipe_pkg::RESET_PC_DEF,
  parameter logic [31:0] HANDLER_PC = pipe_pkg::HANDLER_PC_DEF
`ifdef PIPE_PERF_EN
  ,
  parameter int          CNT_W      = 16
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               req,
  input  logic               in_valid,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [EXC_W-1:0]   in_exccode,
  input  logic               in_bd,
  output logic               out_valid,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [EXC_W-1:0]   out_exccode,
  output logic               out_bd
`ifdef PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
`endif
);

  // PC constants keep only their low PC_W bits, zero-extended when PC_W is wider.
  localparam logic [PC_W-1:0] RESET_PC_L   = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] HANDLER_PC_L = PC_W'(HANDLER_PC);

  logic               valid_q, valid_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [EXC_W-1:0]   exccode_q, exccode_d;
  logic               bd_q, bd_d;
  stage_act_e         act;

  assign act = selectAction(req, flush, stall);

  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    exccode_d = exccode_q;
    bd_d      = bd_q;
    case (act)
      ACT_REQ: begin
        valid_d   = 1'b0;
        pc_d      = HANDLER_PC_L;
        instr_d   = '0;
        exccode_d = '0;
        bd_d      = 1'b0;
      end
      // The bubble keeps its PC so a later exception still reports a sane EPC.
      ACT_FLUSH: begin
        valid_d   = 1'b0;
        pc_d      = in_pc;
        instr_d   = '0;
        exccode_d = '0;
        bd_d      = 1'b0;
      end
      ACT_LOAD: begin
        valid_d   = in_valid;
        pc_d      = in_pc;
        bd_d      = in_bd;
        instr_d   = in_valid ? in_instr : '0;
        exccode_d = in_valid ? in_exccode : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      pc_q      <= RESET_PC_L;
      instr_q   <= '0;
      exccode_q <= '0;
      bd_q      <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      exccode_q <= exccode_d;
      bd_q      <= bd_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_pc      = pc_q;
  assign out_instr   = instr_q;
  assign out_exccode = exccode_q;
  assign out_bd      = bd_q;

`ifdef PIPE_PERF_EN
  // A load of an empty slot counts as a bubble just like a flush or redirect.
  logic stallEvent;
  logic bubbleEvent;

  assign stallEvent  = (act == ACT_STALL);
  assign bubbleEvent = (act == ACT_REQ) || (act == ACT_FLUSH) ||
                       ((act == ACT_LOAD) && !in_valid);

  pipe_sat_cnt #(.CNT_W(CNT_W)) uStallCnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stallEvent),
    .count (stall_cnt)
  );

  pipe_sat_cnt #(.CNT_W(CNT_W)) uBubbleCnt (
    .clk   (clk),
    .reset (reset),
    .inc   (bubbleEvent),
    .count (bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus random traffic
// compared against a behavioural model of the stage contents and counters.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  logic        clk;
  logic        reset;
  logic        stall, flush, req;
  logic        inValid;
  logic [31:0] inPc;
  logic [31:0] inInstr;
  logic [4:0]  inExccode;
  logic        inBd;

  logic        outValid;
  logic [31:0] outPc;
  logic [31:0] outInstr;
  logic [4:0]  outExccode;
  logic        outBd;

  int passCount;
  int checkCount;

  stage_t expStage;
  longint stallEvents;
  longint bubbleEvents;

`ifdef PIPE_PERF_EN
  logic [15:0] stallCnt, bubbleCnt;
  logic [1:0]  smallStallCnt, smallBubbleCnt;
  logic        sValid, sBd;
  logic [31:0] sPc, sInstr;
  logic [4:0]  sExccode;
`endif

  pipe_stage_reg dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .req         (req),
    .in_valid    (inValid),
    .in_pc       (inPc),
    .in_instr    (inInstr),
    .in_exccode  (inExccode),
    .in_bd       (inBd),
    .out_valid   (outValid),
    .out_pc      (outPc),
    .out_instr   (outInstr),
    .out_exccode (outExccode),
    .out_bd      (outBd)
`ifdef PIPE_PERF_EN
    ,
    .stall_cnt   (stallCnt),
    .bubble_cnt  (bubbleCnt)
`endif
  );

`ifdef PIPE_PERF_EN
  pipe_stage_reg #(.CNT_W(2)) dutSmall (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .req         (req),
    .in_valid    (inValid),
    .in_pc       (inPc),
    .in_instr    (inInstr),
    .in_exccode  (inExccode),
    .in_bd       (inBd),
    .out_valid   (sValid),
    .out_pc      (sPc),
    .out_instr   (sInstr),
    .out_exccode (sExccode),
    .out_bd      (sBd),
    .stall_cnt   (smallStallCnt),
    .bubble_cnt  (smallBubbleCnt)
  );
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [63:0] saturate(input longint n, input int w);
    longint maxVal;
    maxVal = (longint'(1) << w) - 1;
    return (n > maxVal) ? 64'(maxVal) : 64'(n);
  endfunction

  function automatic void modelReset();
    expStage     = '{valid: 1'b0, pc: 32'h0000_3000, instr: '0, exccode: EXC_NONE, bd: 1'b0};
    stallEvents  = 0;
    bubbleEvents = 0;
  endfunction

  // What the stage should hold after one rising edge, straight from the priority rules.
  function automatic void modelEdge();
    if (req) begin
      expStage = '{valid: 1'b0, pc: 32'h0000_4180, instr: '0, exccode: '0, bd: 1'b0};
      bubbleEvents++;
    end else if (flush) begin
      expStage = '{valid: 1'b0, pc: inPc, instr: '0, exccode: '0, bd: 1'b0};
      bubbleEvents++;
    end else if (stall) begin
      stallEvents++;
    end else if (inValid) begin
      expStage = '{valid: 1'b1, pc: inPc, instr: inInstr, exccode: inExccode, bd: inBd};
    end else begin
      expStage = '{valid: 1'b0, pc: inPc, instr: '0, exccode: '0, bd: inBd};
      bubbleEvents++;
    end
  endfunction

  task automatic checkAll(input string tag);
    checkOutput({tag, ".valid"},   64'(outValid),   64'(expStage.valid));
    checkOutput({tag, ".pc"},      64'(outPc),      64'(expStage.pc));
    checkOutput({tag, ".instr"},   64'(outInstr),   64'(expStage.instr));
    checkOutput({tag, ".exccode"}, 64'(outExccode), 64'(expStage.exccode));
    checkOutput({tag, ".bd"},      64'(outBd),      64'(expStage.bd));
`ifdef PIPE_PERF_EN
    checkOutput({tag, ".stall_cnt"},   64'(stallCnt),       saturate(stallEvents, 16));
    checkOutput({tag, ".bubble_cnt"},  64'(bubbleCnt),      saturate(bubbleEvents, 16));
    checkOutput({tag, ".stall_cnt2"},  64'(smallStallCnt),  saturate(stallEvents, 2));
    checkOutput({tag, ".bubble_cnt2"}, 64'(smallBubbleCnt), saturate(bubbleEvents, 2));
`endif
  endtask

  task automatic randomizeInputs();
    stall     = 1'($urandom);
    flush     = 1'($urandom);
    req       = 1'($urandom);
    inValid   = 1'($urandom);
    inPc      = $urandom;
    inInstr   = $urandom;
    inExccode = 5'($urandom);
    inBd      = 1'($urandom);
  endtask

  // Drives one cycle of inputs, lets an edge pass, then checks just after it.
  task automatic applyStimulus(input string tag, input logic r, input logic f, input logic s,
                               input logic v, input logic [31:0] pc, input logic [31:0] instr,
                               input logic [4:0] exc, input logic bd);
    req = r; flush = f; stall = s;
    inValid = v; inPc = pc; inInstr = instr; inExccode = exc; inBd = bd;
    @(posedge clk);
    modelEdge();
    #1;
    checkAll(tag);
  endtask

  initial begin
    passCount  = 0;
    checkCount = 0;
    reset      = 1'b1;
    randomizeInputs();
    modelReset();

    // Reset dominates every random control combination, independent of edges.
    repeat (3) begin
      @(posedge clk);
      #1;
      randomizeInputs();
      #1;
      checkAll("reset_hold");
    end
    @(posedge clk);
    #1;
    req = 0; flush = 0; stall = 0;
    inValid = 1; inPc = 32'h3004; inInstr = 32'h0000_0000; inExccode = 0; inBd = 0;
    #1;
    checkAll("reset_pc");
    reset = 1'b0;
    applyStimulus("load_3004", 0, 0, 0, 1, 32'h3004, 32'h0000_0000, 5'd0, 0);

    applyStimulus("load_3008", 0, 0, 0, 1, 32'h3008, 32'h2408_0001, 5'd0, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("stall", 0, 0, 1, 1, $urandom, $urandom, 5'($urandom), 1'($urandom));
    end
    applyStimulus("flush_stall", 0, 1, 1, 1, 32'h300c, 32'hdead_beef, 5'd7, 1);
    applyStimulus("req_all", 1, 1, 1, 1, 32'h3010, 32'hcafe_f00d, 5'd3, 1);
    applyStimulus("after_req", 0, 0, 0, 1, 32'h3014, 32'h0123_4567, 5'd0, 0);
    applyStimulus("exc_keep", 0, 0, 0, 1, 32'h3018, 32'h89ab_cdef, 5'd4, 0);
    applyStimulus("exc_drop", 0, 0, 0, 0, 32'h301c, 32'h89ab_cdef, 5'd4, 1);

    // Random traffic with controls biased toward loads.
    for (int i = 0; i < 300; i++) begin
      applyStimulus("random", ($urandom_range(15) == 0), ($urandom_range(7) == 0),
                    ($urandom_range(3) == 0), ($urandom_range(3) != 0), $urandom, $urandom,
                    (($urandom_range(3) == 0) ? 5'($urandom) : 5'd0), 1'($urandom));
    end

    // Asynchronous reset in the middle of a stall discards everything at once.
    applyStimulus("pre_rst_stall", 0, 0, 1, 1, 32'h5000, 32'h1, 5'd2, 1);
    #3;
    reset = 1'b1;
    #1;
    modelReset();
    checkAll("rst_mid_stall");
    req = 1;
    @(posedge clk);
    #1;
    checkAll("rst_over_req");
    reset = 1'b0;
    applyStimulus("post_rst_req", 1, 0, 0, 1, 32'h6000, 32'h2, 5'd1, 1);
    applyStimulus("post_rst_load", 0, 0, 0, 1, 32'h6004, 32'h3, 5'd0, 1);

    // Long stall run drives the narrow counters into saturation.
    for (int i = 0; i < 5; i++) begin
      applyStimulus("sat_stall", 0, 0, 1, 0, $urandom, $urandom, 5'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter PC_W, default 32: width of the PC field.
REQ-002 Parameter INSTR_W, default 32: width of the instruction field.
REQ-003 Parameter EXC_W, default 5: width of the exception-code field.
REQ-004 Parameter RESET_PC, default 32'h0000_3000: PC loaded on reset.
REQ-005 Parameter HANDLER_PC, default 32'h0000_4180: PC loaded on exception request.
REQ-006 Parameter CNT_W, default 16: width of the performance counters.
REQ-007 clk  input  1  single clock; all state updates on its rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 stall  input  1  hold the current contents.
REQ-010 flush  input  1  replace the next contents with a bubble (branch clear or hazard bubble).
REQ-011 req  input  1  exception/interrupt request; redirects the stage to the handler.
REQ-012 in_valid  input  1  upstream slot holds a real instruction.
REQ-013 in_pc  input  PC_W  upstream PC.
REQ-014 in_instr  input  INSTR_W  upstream instruction word.
REQ-015 in_exccode  input  EXC_W  upstream exception code; 0 means none.
REQ-016 in_bd  input  1  upstream instruction is in a branch delay slot.
REQ-017 out_valid, out_pc, out_instr, out_exccode, out_bd  output  1/PC_W/INSTR_W/EXC_W/1  registered stage contents.
REQ-018 stall_cnt, bubble_cnt  output  CNT_W  performance counters; present only under PIPE_PERF_EN.

Function
REQ-019 Per-edge priority is fixed: req > flush > stall > load.
REQ-020 On req, out_pc = HANDLER_PC and out_valid, out_instr, out_exccode and out_bd = 0; req overrides both stall and flush.
REQ-021 On flush without req, out_pc = in_pc and all other outputs = 0, whether or not stall is set; the bubble carries its PC so the downstream EPC stays correct.
REQ-022 On stall alone, every output holds its value.
REQ-023 On load, the outputs take the in_* values one cycle later (latency 1), with no combinational path from input to output.
REQ-024 On load with in_valid=0, out_instr and out_exccode are forced to 0; out_pc and out_bd pass through unchanged.
REQ-025 A nonzero in_exccode is kept unchanged in out_exccode; the stage never creates or clears an exception code except under REQ-020, REQ-021 and REQ-024.
REQ-026 When a PC value is wider or narrower than PC_W, only its low PC_W bits are kept, with no sign extension.

Reset
REQ-027 While reset is high, out_pc = RESET_PC, all other outputs = 0, and the counters = 0, independent of clk.
REQ-028 Reset wins over req, flush and stall; on the first edge after release the stage obeys REQ-019.
REQ-029 Reset asserted mid-stall or during req discards all held state, with no partial update.

Configuration
REQ-030 With PIPE_PERF_EN defined, stall_cnt increments on each edge that applies REQ-022, and bubble_cnt increments on each edge that applies REQ-020, REQ-021 or REQ-024.
REQ-031 Both counters saturate at all-ones and never wrap.
REQ-032 Without PIPE_PERF_EN, the counter ports and their logic are absent, and the remaining behaviour is identical bit for bit.

Structure
REQ-033 Package pipe_pkg holds the RESET_PC and HANDLER_PC defaults, EXC_NONE (= 0), EXC_W, and a stage-contents struct typedef {valid, pc, instr, exccode, bd}.
REQ-034 One sub-module, pipe_sat_cnt (CNT_W parameter; inputs clk, reset, inc; output count; saturating), is instantiated twice under PIPE_PERF_EN.

Verification
REQ-035 Reset: hold reset high with every input random; release; then load in_pc=32'h3004 -> out_pc=32'h3000 during reset, and out_pc=32'h3004 with out_valid=1 one edge after the load.
REQ-036 Stall: load 32'h3008 / instr 32'h2408_0001, then stall for 3 edges -> outputs unchanged, and stall_cnt=3 under PIPE_PERF_EN.
REQ-037 Flush during stall: stall=1, flush=1, in_pc=32'h300c -> out_valid=0, out_instr=0, out_pc=32'h300c, bubble_cnt+1.
REQ-038 Exception: req=1 together with stall=1 and flush=1 -> out_pc=32'h4180, all other outputs 0; the next load behaves normally.
REQ-039 Exception code: load in_exccode=5'd4 with in_valid=1 -> out_exccode=4; then load in_valid=0 with in_exccode=4 -> out_exccode=0.
REQ-040 Saturation: CNT_W=2, hold stall for 5 edges -> stall_cnt=3 and stays at 3.
